multi_shift_calc: RTL and testbench

Pipelined, multi-lane exponent alignment unit for the systolic-array dot-product datapath. Computes out = Σ(a_i·b_i) + acc for LANES products: forms each product exponent, finds the common output exponent across all lanes and the accumulator, and returns the saturated right-shift per lane and for the accumulator. Sits between the operand unpack stage and the mantissa shifters/adder tree. Two register stages with valid/ready flow control.

---
 rtl/multi_shift_calc.sv | 146 ++++++++++++++
 tb/tb_multi_shift_calc.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_shift_calc.sv
// Two-stage exponent alignment for the dot-product datapath:
// product exponents, common max exponent, saturated per-lane shifts.
module multi_shift_calc #(
    parameter int LANES      = 4,
    parameter int EXP_W      = 8,
    parameter int EXP_BIAS   = 127,
    parameter int MUL_MANT_W = 8,
    parameter int ACC_MANT_W = 32,
    parameter int TAG_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*EXP_W-1:0]   in_exp_a,
    input  logic [LANES*EXP_W-1:0]   in_exp_b,
    input  logic [EXP_W-1:0]         in_exp_acc,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W-1:0]         out_exp,
    output logic [LANES*$clog2(2*MUL_MANT_W+1)-1:0] out_mul_shift,
    output logic [$clog2(ACC_MANT_W+1)-1:0]         out_acc_shift,
    output logic [LANES-1:0]         out_zero,
    output logic                     out_inf,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int MUL_SAT = 2 * MUL_MANT_W;
    localparam int ACC_SAT = ACC_MANT_W;
    localparam int MSH_W   = $clog2(MUL_SAT + 1);
    localparam int ASH_W   = $clog2(ACC_SAT + 1);
    localparam int SW      = EXP_W + 2;

    localparam logic signed [SW-1:0] BIAS_S  = SW'(EXP_BIAS);
    localparam logic signed [SW-1:0] INF_LIM = SW'((1 << EXP_W) - 1);
    localparam logic signed [SW-1:0] MSAT_S  = SW'(MUL_SAT);
    localparam logic signed [SW-1:0] ASAT_S  = SW'(ACC_SAT);

    logic                    s1_valid;
    logic signed [SW-1:0]    s1_em [LANES];
    logic [LANES-1:0]        s1_zero;
    logic                    s1_inf;
    logic [EXP_W-1:0]        s1_acc;
    logic [TAG_W-1:0]        s1_tag;

    logic                    s1_load;
    logic                    s2_load;

    logic signed [SW-1:0]    em_c [LANES];
    logic [LANES-1:0]        zero_c;
    logic                    inf_c;

    logic signed [SW-1:0]    mx;
    logic signed [SW-1:0]    diff;
    logic [EXP_W-1:0]        exp_c;
    logic [LANES*MSH_W-1:0]  msh_c;
    logic [ASH_W-1:0]        ash_c;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        em_c   = '{default: '0};
        zero_c = '0;
        inf_c  = &in_exp_acc;
        for (int i = 0; i < LANES; i++) begin
            em_c[i] = $signed({2'b00, in_exp_a[i*EXP_W +: EXP_W]})
                    + $signed({2'b00, in_exp_b[i*EXP_W +: EXP_W]})
                    - BIAS_S;
            zero_c[i] = em_c[i][SW-1];
            inf_c = inf_c
                  | (em_c[i] >= INF_LIM)
                  | (&in_exp_a[i*EXP_W +: EXP_W])
                  | (&in_exp_b[i*EXP_W +: EXP_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_em    <= '{default: '0};
            s1_zero  <= '0;
            s1_inf   <= 1'b0;
            s1_acc   <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            s1_em    <= em_c;
            s1_zero  <= zero_c;
            s1_inf   <= inf_c;
            s1_acc   <= in_exp_acc;
            s1_tag   <= in_tag;
        end
    end

    // Underflowed lanes never set the common exponent; without overflow
    // the max fits in EXP_W bits, so the shift differences are non-negative.
    always_comb begin
        mx = $signed({2'b00, s1_acc});
        for (int i = 0; i < LANES; i++) begin
            if (!s1_zero[i] && s1_em[i] > mx) begin
                mx = s1_em[i];
            end
        end
        exp_c = mx[EXP_W-1:0];
        msh_c = '0;
        diff  = '0;
        for (int i = 0; i < LANES; i++) begin
            diff = mx - s1_em[i];
            if (s1_zero[i] || diff > MSAT_S) begin
                msh_c[i*MSH_W +: MSH_W] = MSH_W'(MUL_SAT);
            end else begin
                msh_c[i*MSH_W +: MSH_W] = diff[MSH_W-1:0];
            end
        end
        diff  = mx - $signed({2'b00, s1_acc});
        ash_c = (diff > ASAT_S) ? ASH_W'(ACC_SAT) : diff[ASH_W-1:0];
        if (s1_inf) begin
            exp_c = '1;
            msh_c = '0;
            ash_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_exp       <= '0;
            out_mul_shift <= '0;
            out_acc_shift <= '0;
            out_zero      <= '0;
            out_inf       <= 1'b0;
            out_tag       <= '0;
        end else if (s2_load) begin
            out_valid     <= s1_valid;
            out_exp       <= exp_c;
            out_mul_shift <= msh_c;
            out_acc_shift <= ash_c;
            out_zero      <= s1_zero;
            out_inf       <= s1_inf;
            out_tag       <= s1_tag;
        end
    end

endmodule

// File: tb/tb_multi_shift_calc.sv
// Bench for multi_shift_calc: directed table, corner sequences
// and random traffic against a scoreboard fed by an arithmetic model.
module tb_multi_shift_calc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_exp_a;
    logic [31:0] in_exp_b;
    logic [7:0]  in_exp_acc;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exp;
    logic [19:0] out_mul_shift;
    logic [5:0]  out_acc_shift;
    logic [3:0]  out_zero;
    logic        out_inf;
    logic [3:0]  out_tag;

    multi_shift_calc dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
        .in_exp_acc(in_exp_acc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_mul_shift(out_mul_shift),
        .out_acc_shift(out_acc_shift), .out_zero(out_zero),
        .out_inf(out_inf), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  acc;
        logic [3:0]  tag;
    } vec_t;

    typedef struct packed {
        logic [7:0]  e;
        logic [19:0] msh;
        logic [5:0]  ash;
        logic [3:0]  z;
        logic        inf;
        logic [3:0]  tag;
    } res_t;

    typedef struct packed {
        vec_t v;
        res_t r;
    } row_t;

    int   total = 0;
    int   bad = 0;
    res_t q[$];
    row_t tbl[9];
    logic accepted;
    logic saw_stall;
    int   emerged;

    function automatic logic [31:0] mk4(int x0, int x1, int x2, int x3);
        return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    function automatic logic [19:0] pk(int s0, int s1, int s2, int s3);
        return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
    endfunction

    function automatic res_t model(vec_t v);
        res_t r;
        int em[4];
        int mx;
        int acc;
        bit inf;
        int sh[4];
        acc = int'(v.acc);
        inf = (acc == 255);
        mx = acc;
        r.z = '0;
        for (int i = 0; i < 4; i++) begin
            int a, b;
            a = int'(v.a[i*8 +: 8]);
            b = int'(v.b[i*8 +: 8]);
            em[i] = a + b - 127;
            r.z[i] = (em[i] < 0);
            if (em[i] >= 255 || a == 255 || b == 255) inf = 1;
            if (em[i] >= 0 && em[i] > mx) mx = em[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (em[i] < 0) sh[i] = 16;
            else sh[i] = (mx - em[i] > 16) ? 16 : mx - em[i];
        end
        r.inf = inf;
        r.tag = v.tag;
        if (inf) begin
            r.e = 8'hFF;
            r.msh = '0;
            r.ash = '0;
        end else begin
            r.e = 8'(mx);
            r.msh = pk(sh[0], sh[1], sh[2], sh[3]);
            r.ash = 6'((mx - acc > 32) ? 32 : mx - acc);
        end
        return r;
    endfunction

    function automatic res_t dut_out();
        return {out_exp, out_mul_shift, out_acc_shift,
                out_zero, out_inf, out_tag};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < 4; i++) begin
            v.a[i*8 +: 8] = ($urandom_range(0, 7) == 0) ?
                8'($urandom_range(0, 255)) : 8'($urandom_range(40, 190));
            v.b[i*8 +: 8] = ($urandom_range(0, 7) == 0) ?
                8'($urandom_range(0, 255)) : 8'($urandom_range(40, 190));
        end
        v.acc = 8'($urandom_range(0, 254));
        v.tag = 4'($urandom);
        return v;
    endfunction

    // One cycle: drive after a negedge, act on the handshakes that the
    // next posedge will take, then return at the following negedge.
    task automatic cycle(input logic v, input vec_t x, input res_t want,
                         input logic ordy);
        res_t held;
        logic hold;
        in_valid   = v;
        in_exp_a   = x.a;
        in_exp_b   = x.b;
        in_exp_acc = x.acc;
        in_tag     = x.tag;
        out_ready  = ordy;
        #1;
        accepted = v && in_ready;
        if (accepted) q.push_back(want);
        if (out_valid && out_ready) begin
            emerged++;
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                chk("result", 64'(dut_out()), 64'(q.pop_front()));
            end
        end
        hold = out_valid && !out_ready;
        held = dut_out();
        @(negedge clk);
        if (hold) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_data", 64'(dut_out()), 64'(held));
        end
    endtask

    task automatic drain();
        vec_t z;
        int n;
        z = '0;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 20) begin
            cycle(1'b0, z, '0, 1'b1);
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    initial begin
        vec_t z;
        vec_t bp[6];
        int idx;
        int c;
        z = '0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_exp_a = '0;
        in_exp_b = '0;
        in_exp_acc = '0;
        in_tag = '0;
        emerged = 0;

        tbl[0].v = '{a: mk4(130, 128, 127, 60), b: mk4(127, 127, 100, 60),
                     acc: 8'd129, tag: 4'd0};
        tbl[0].r = '{e: 8'd130, msh: pk(0, 2, 16, 16), ash: 6'd1,
                     z: 4'b1000, inf: 1'b0, tag: 4'd0};
        tbl[1].v = '{a: mk4(127, 127, 127, 127), b: mk4(127, 127, 127, 127),
                     acc: 8'd200, tag: 4'd1};
        tbl[1].r = '{e: 8'd200, msh: pk(16, 16, 16, 16), ash: 6'd0,
                     z: 4'b0000, inf: 1'b0, tag: 4'd1};
        tbl[2].v = '{a: mk4(255, 127, 127, 127), b: mk4(1, 127, 127, 127),
                     acc: 8'd127, tag: 4'd2};
        tbl[2].r = '{e: 8'd255, msh: '0, ash: 6'd0,
                     z: 4'b0000, inf: 1'b1, tag: 4'd2};
        tbl[3].v = '{a: mk4(127, 200, 127, 127), b: mk4(127, 200, 127, 127),
                     acc: 8'd127, tag: 4'd3};
        tbl[3].r = '{e: 8'd255, msh: '0, ash: 6'd0,
                     z: 4'b0000, inf: 1'b1, tag: 4'd3};
        tbl[4].v = '{a: mk4(127, 127, 127, 127), b: mk4(127, 127, 127, 127),
                     acc: 8'd127, tag: 4'd4};
        tbl[4].r = '{e: 8'd127, msh: pk(0, 0, 0, 0), ash: 6'd0,
                     z: 4'b0000, inf: 1'b0, tag: 4'd4};
        tbl[5].v = '{a: mk4(10, 10, 10, 10), b: mk4(10, 10, 10, 10),
                     acc: 8'd0, tag: 4'd5};
        tbl[5].r = '{e: 8'd0, msh: pk(16, 16, 16, 16), ash: 6'd0,
                     z: 4'b1111, inf: 1'b0, tag: 4'd5};
        tbl[6].v = '{a: mk4(254, 127, 127, 127), b: mk4(127, 127, 127, 127),
                     acc: 8'd0, tag: 4'd6};
        tbl[6].r = '{e: 8'd254, msh: pk(0, 16, 16, 16), ash: 6'd32,
                     z: 4'b0000, inf: 1'b0, tag: 4'd6};
        tbl[7].v = '{a: mk4(254, 127, 127, 127), b: mk4(128, 127, 127, 127),
                     acc: 8'd0, tag: 4'd7};
        tbl[7].r = '{e: 8'd255, msh: '0, ash: 6'd0,
                     z: 4'b0000, inf: 1'b1, tag: 4'd7};
        tbl[8].v = '{a: mk4(127, 0, 0, 0), b: mk4(0, 0, 0, 0),
                     acc: 8'd0, tag: 4'd8};
        tbl[8].r = '{e: 8'd0, msh: pk(0, 16, 16, 16), ash: 6'd0,
                     z: 4'b1110, inf: 1'b0, tag: 4'd8};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_data", 64'(dut_out()), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Latency: two register stages from accept to result
        cycle(1'b1, tbl[4].v, tbl[4].r, 1'b1);
        chk("lat_early", 64'(out_valid), 64'(0));
        cycle(1'b0, z, '0, 1'b1);
        chk("lat_on", 64'(out_valid), 64'(1));
        drain();

        // Directed table, back-to-back with out_ready high
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, tbl[i].v, tbl[i].r, 1'b1);
            chk("tbl_accept", 64'(accepted), 64'(1));
        end
        drain();

        // Backpressure: out_ready low on stream cycles 3..5
        for (int i = 0; i < 6; i++) begin
            bp[i] = rnd_vec();
            bp[i].tag = 4'(i);
        end
        idx = 0;
        c = 0;
        saw_stall = 1'b0;
        emerged = 0;
        while ((idx < 6 || q.size() != 0) && c < 40) begin
            if (idx < 6) begin
                cycle(1'b1, bp[idx], model(bp[idx]), !(c >= 3 && c <= 5));
                if (accepted) idx++;
                else saw_stall = 1'b1;
            end else begin
                cycle(1'b0, z, '0, 1'b1);
            end
            c++;
        end
        chk("bp_stall_seen", 64'(saw_stall), 64'(1));
        chk("bp_count", 64'(emerged), 64'(6));
        chk("bp_empty", 64'(q.size()), 64'(0));

        // Reset with two vectors in flight
        cycle(1'b1, tbl[0].v, tbl[0].r, 1'b0);
        cycle(1'b1, tbl[1].v, tbl[1].r, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        emerged = 0;
        for (int i = 0; i < 5; i++) cycle(1'b0, z, '0, 1'b1);
        chk("rst_no_stale", 64'(emerged), 64'(0));
        cycle(1'b1, tbl[5].v, tbl[5].r, 1'b1);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = rnd_vec();
            cycle(1'($urandom_range(0, 3) != 0), v, model(v),
                  1'($urandom_range(0, 4) != 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
